// File: rtl/batch_arb_pkg.sv
// Shared types for the batch arbiter and its round-robin picker.
package batch_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        logic             w_found;
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_k;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_found = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < N; i++) begin
            // ptr < N and i < N, so one conditional subtract is a full modulo
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            w_k = w_sum[IDX_W-1:0];
            if (!w_found && i_valid[w_k]) begin
                w_found    = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/batch_arbiter.sv
// Round-robin batch scheduler sharing one A/B operand path between NREQ requesters.
// Optional per-requester batch counters: define BATCH_ARBITER_STATS_EN.
module batch_arbiter
    import batch_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int ITEM_WIDTH = 8,
    parameter int MAX_BEATS  = 1000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ*ITEM_WIDTH-1:0] req_a_i,
    input  logic [NREQ*ITEM_WIDTH-1:0] req_b_i,
    input  logic [NREQ-1:0]            req_last_i,
    output logic [NREQ-1:0]            req_ready_o,
    output logic [ITEM_WIDTH-1:0]      a_o,
    output logic [ITEM_WIDTH-1:0]      b_o,
    output logic                       op_valid_o,
    input  logic                       op_ready_i,
    output logic [NREQ-1:0]            grant_o,
    output logic                       busy_o,
    output logic                       batch_done_o,
    output logic [$clog2(NREQ)-1:0]    batch_id_o,
    output logic                       overrun_o
`ifdef BATCH_ARBITER_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0]    stat_sel_i,
    output logic [STAT_W-1:0]          stat_cnt_o
`endif
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return (g == ID_W'(NREQ - 1)) ? '0 : g + ID_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    state_t                r_state, w_state_nxt;
    logic [NREQ-1:0]       r_grant;
    logic [ID_W-1:0]       r_gidx;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]      r_beat;
    logic [ITEM_WIDTH-1:0] r_a, r_b;
    logic                  r_opv, r_done, r_ovr;
    logic [ID_W-1:0]       r_id;

    logic [NREQ-1:0]       w_pick_grant, w_ready;
    logic [ID_W-1:0]       w_pick_idx;
    logic                  w_pick_any, w_slot, w_xfer, w_last, w_end;
    logic [ITEM_WIDTH-1:0] w_a, w_b;

    rr_pick #(.N(NREQ), .IDX_W(ID_W)) u_pick (
        .i_valid (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Output register may take a new pair if empty or being drained this cycle
    assign w_slot = !r_opv || op_ready_i;
    assign w_a    = req_a_i[r_gidx*ITEM_WIDTH +: ITEM_WIDTH];
    assign w_b    = req_b_i[r_gidx*ITEM_WIDTH +: ITEM_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any)
                    w_state_nxt = STREAM;
            end
            STREAM: begin
                w_ready = r_grant & {NREQ{w_slot}};
                w_xfer  = req_valid_i[r_gidx] && w_slot;
                w_last  = req_last_i[r_gidx];
                w_end   = w_xfer && (w_last || (r_beat == LAST_BEAT));
                if (w_end)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_beat   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_opv    <= 1'b0;
            r_done   <= 1'b0;
            r_id     <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_end;
            r_ovr   <= w_end && !w_last;
            if (r_state == IDLE && w_pick_any) begin
                r_grant <= w_pick_grant;
                r_gidx  <= w_pick_idx;
                r_beat  <= '0;
            end
            if (w_xfer) begin
                r_a    <= w_a;
                r_b    <= w_b;
                r_opv  <= 1'b1;
                r_beat <= r_beat + CNT_W'(1);
            end else if (op_ready_i) begin
                r_opv <= 1'b0;
            end
            if (w_end) begin
                r_grant  <= '0;
                r_id     <= r_gidx;
                r_rr_ptr <= next_ptr(r_gidx);
                r_beat   <= '0;
            end
        end
    end

    assign req_ready_o  = w_ready;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign op_valid_o   = r_opv;
    assign grant_o      = r_grant;
    assign busy_o       = (r_state == STREAM);
    assign batch_done_o = r_done;
    assign batch_id_o   = r_id;
    assign overrun_o    = r_ovr;

`ifdef BATCH_ARBITER_STATS_EN
    logic [STAT_W-1:0] r_stat [NREQ];
    logic [STAT_W-1:0] r_stat_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NREQ; i++)
                r_stat[i] <= '0;
            r_stat_cnt <= '0;
        end else begin
            if (w_end)
                r_stat[r_gidx] <= sat_inc(r_stat[r_gidx]);
            r_stat_cnt <= r_stat[stat_sel_i];
        end
    end

    assign stat_cnt_o = r_stat_cnt;
`endif

endmodule
